// File: rtl/alu_issue.sv
// Execute-stage issue block: decodes ALU control, buffers entries in a 2-deep skid buffer.
// Define ALU_ISSUE_FWD_EN to forward the last retired ALU result into operands at accept.
module alu_issue #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5,
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_alu_op,
    input  logic [5:0]    in_funct,
    input  logic [DW-1:0] in_src1,
    input  logic [DW-1:0] in_src2,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [RW-1:0] in_dst,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    output logic [2:0]    alu_ctr,
    output logic [RW-1:0] out_dst,
    input  logic [DW-1:0] alu_result,
    output logic          illegal_funct,
    output logic [CW-1:0] issue_cnt
);

    logic          accept, fire;
    logic [2:0]    dec_ctr;
    logic          dec_illegal;
    logic [DW-1:0] new_src1, new_src2;

    logic          s_valid, s_valid_nxt, s_load, s_drain;
    logic [DW-1:0] s_src1, s_src2;
    logic [2:0]    s_ctr;
    logic [RW-1:0] s_dst;

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    always_comb begin
        dec_ctr     = 3'b010;
        dec_illegal = 1'b0;
        case (in_alu_op)
            2'b00: dec_ctr = 3'b010;
            2'b01: dec_ctr = 3'b110;
            2'b11: dec_ctr = 3'b001;
            default: begin
                case (in_funct)
                    6'b100000: dec_ctr = 3'b010;
                    6'b100010: dec_ctr = 3'b110;
                    6'b100100: dec_ctr = 3'b000;
                    6'b100101: dec_ctr = 3'b001;
                    6'b101010: dec_ctr = 3'b111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    logic          rec_valid;
    logic [RW-1:0] last_dst;
    logic [DW-1:0] last_res;

    // The result retiring this very cycle is newer than the stored record.
    always_comb begin
        new_src1 = in_src1;
        new_src2 = in_src2;
        if (in_rs != '0) begin
            if (fire && out_dst == in_rs)
                new_src1 = alu_result;
            else if (rec_valid && last_dst == in_rs)
                new_src1 = last_res;
        end
        if (in_rt != '0) begin
            if (fire && out_dst == in_rt)
                new_src2 = alu_result;
            else if (rec_valid && last_dst == in_rt)
                new_src2 = last_res;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rec_valid <= 1'b0;
            last_dst  <= '0;
            last_res  <= '0;
        end else if (fire) begin
            rec_valid <= 1'b1;
            last_dst  <= out_dst;
            last_res  <= alu_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{alu_result, in_rs, in_rt};
    assign new_src1   = in_src1;
    assign new_src2   = in_src2;
`endif

    // S fills only when O is held; it drains whenever O fires.
    assign s_load      = accept & out_valid & ~out_ready;
    assign s_drain     = fire & s_valid;
    assign s_valid_nxt = s_load | (s_valid & ~s_drain);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            alu_src1      <= '0;
            alu_src2      <= '0;
            alu_ctr       <= 3'b010;
            out_dst       <= '0;
            s_valid       <= 1'b0;
            s_src1        <= '0;
            s_src2        <= '0;
            s_ctr         <= 3'b010;
            s_dst         <= '0;
            illegal_funct <= 1'b0;
            issue_cnt     <= '0;
        end else begin
            s_valid  <= s_valid_nxt;
            in_ready <= ~s_valid_nxt;
            if (s_drain) begin
                alu_src1 <= s_src1;
                alu_src2 <= s_src2;
                alu_ctr  <= s_ctr;
                out_dst  <= s_dst;
            end else if (accept && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                alu_src1  <= new_src1;
                alu_src2  <= new_src2;
                alu_ctr   <= dec_ctr;
                out_dst   <= in_dst;
            end else if (s_load) begin
                s_src1 <= new_src1;
                s_src2 <= new_src2;
                s_ctr  <= dec_ctr;
                s_dst  <= in_dst;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
            if (accept && dec_illegal)
                illegal_funct <= 1'b1;
            if (fire)
                issue_cnt <= issue_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_issue;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          in_valid, in_ready;
    logic [1:0]    in_alu_op;
    logic [5:0]    in_funct;
    logic [DW-1:0] in_src1, in_src2;
    logic [RW-1:0] in_rs, in_rt, in_dst;
    logic          out_valid, out_ready;
    logic [DW-1:0] alu_src1, alu_src2;
    logic [2:0]    alu_ctr;
    logic [RW-1:0] out_dst;
    logic [DW-1:0] alu_result;
    logic          illegal_funct;
    logic [CW-1:0] issue_cnt;

    always #5 Clk = ~Clk;

    alu_issue #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_funct(in_funct),
        .in_src1(in_src1), .in_src2(in_src2),
        .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
        .out_dst(out_dst), .alu_result(alu_result),
        .illegal_funct(illegal_funct), .issue_cnt(issue_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [2:0]    ctr;
        logic [RW-1:0] dst;
    } ent_t;

    ent_t          q[$];
    ent_t          shown;
    bit            m_rdy, m_ill, rec_v, started;
    int unsigned   m_cnt;
    logic [RW-1:0] rec_dst;
    logic [DW-1:0] rec_res;

    function automatic logic [2:0] ref_ctr(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 3'b010;
        if (op == 2'b01) return 3'b110;
        if (op == 2'b11) return 3'b001;
        case (fn)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2a: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [1:0] op, input logic [5:0] fn);
        return op == 2'b10 && !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
    endfunction

    function automatic logic [DW-1:0] ref_fwd(input logic [RW-1:0] tag, input logic [DW-1:0] v, input bit f);
`ifdef ALU_ISSUE_FWD_EN
        if (tag == 0) return v;
        if (f && q[0].dst == tag) return alu_result;
        if (rec_v && rec_dst == tag) return rec_res;
`endif
        return v;
    endfunction

    // Reference model: buffer contents as an in-order queue of at most two entries.
    initial forever begin
        ent_t e;
        bit f, a;
        @(posedge Clk);
        started = 1;
        if (Reset) begin
            q.delete();
            shown = '{s1: '0, s2: '0, ctr: 3'b010, dst: '0};
            m_rdy = 0; m_ill = 0; m_cnt = 0; rec_v = 0;
        end else begin
            f = q.size() > 0 && out_ready;
            a = in_valid && m_rdy;
            e.s1  = ref_fwd(in_rs, in_src1, f);
            e.s2  = ref_fwd(in_rt, in_src2, f);
            e.ctr = ref_ctr(in_alu_op, in_funct);
            e.dst = in_dst;
            if (f) begin
                rec_v = 1; rec_dst = q[0].dst; rec_res = alu_result;
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (a) begin
                q.push_back(e);
                if (ref_illegal(in_alu_op, in_funct)) m_ill = 1;
            end
            m_rdy = q.size() < 2;
            if (q.size() > 0) shown = q[0];
        end
    end

    initial forever begin
        @(negedge Clk);
        if (started) begin
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, q.size() > 0);
            chk("alu_src1", alu_src1, shown.s1);
            chk("alu_src2", alu_src2, shown.s2);
            chk("alu_ctr", alu_ctr, shown.ctr);
            chk("out_dst", out_dst, shown.dst);
            chk("illegal_funct", illegal_funct, m_ill);
            chk("issue_cnt", issue_cnt, m_cnt);
        end
    end

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] dst);
        in_valid = 1; in_alu_op = op; in_funct = fn; in_src1 = a; in_src2 = b;
        in_rs = rs; in_rt = rt; in_dst = dst;
    endtask

    task automatic step;
        @(negedge Clk);
    endtask

    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h07};

    initial begin
        Reset = 1; in_valid = 0; out_ready = 0; alu_result = '0;
        drive(2'b00, 6'h0, '0, '0, '0, '0, '0);
        in_valid = 0;
        repeat (2) step;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_ctr", alu_ctr, 3'b010);
        chk("rst_issue_cnt", issue_cnt, 0);
        Reset = 0;
        step;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // slt decode, 1-cycle latency
        out_ready = 1;
        drive(2'b10, 6'b101010, 5, 9, 1, 2, 7);
        step; in_valid = 0;
        chk("slt_valid", out_valid, 1);
        chk("slt_ctr", alu_ctr, 3'b111);
        chk("slt_src1", alu_src1, 5);
        chk("slt_src2", alu_src2, 9);
        step;
        chk("slt_cnt", issue_cnt, 1);

        // three back-to-back with consumer stalled
        out_ready = 0;
        drive(2'b00, 6'h0, 1, 2, 0, 0, 1); step;
        drive(2'b01, 6'h0, 3, 4, 0, 0, 2); step;
        drive(2'b11, 6'h0, 5, 6, 0, 0, 3); step;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_o_dst", out_dst, 1);
        chk("stall_o_src1", alu_src1, 1);
        out_ready = 1;
        step;
        chk("drain2_dst", out_dst, 2);
        chk("drain2_ctr", alu_ctr, 3'b110);
        chk("drain2_in_ready", in_ready, 1);
        step; in_valid = 0;
        chk("drain3_dst", out_dst, 3);
        chk("drain3_ctr", alu_ctr, 3'b001);
        step;
        chk("drain_cnt", issue_cnt, 4);
        chk("drain_empty", out_valid, 0);

        // undefined funct is sticky
        drive(2'b10, 6'b000111, 8, 8, 0, 0, 4); step;
        chk("illegal_ctr", alu_ctr, 3'b010);
        chk("illegal_flag", illegal_funct, 1);
        drive(2'b10, 6'b100100, 8, 8, 0, 0, 4); step; in_valid = 0; step;
        chk("illegal_sticky", illegal_funct, 1);
        chk("illegal_cnt", issue_cnt, 6);

        // sub of equal operands
        drive(2'b01, 6'h0, 32'h10, 32'h10, 0, 0, 6); step; in_valid = 0;
        chk("sub_ctr", alu_ctr, 3'b110);
        chk("sub_zero_path", alu_src1 - alu_src2, 0);
        step;

        // forwarding: same-cycle result, then stored record
        drive(2'b00, 6'h0, 32'h100, 32'h200, 0, 0, 3); step;
        drive(2'b00, 6'h0, 32'h1, 32'h2, 3, 9, 4); alu_result = 32'hDEAD; step;
        drive(2'b00, 6'h0, 32'h77, 32'h88, 0, 3, 5); alu_result = 32'hBEEF;
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_same_cycle", alu_src1, 32'hDEAD);
`else
        chk("fwd_passthru1", alu_src1, 32'h1);
`endif
        chk("fwd_nomatch_src2", alu_src2, 32'h2);
        step; in_valid = 0;
        chk("fwd_rs0_keep", alu_src1, 32'h77);
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_record_src2", alu_src2, 32'hDEAD);
`else
        chk("fwd_passthru2", alu_src2, 32'h88);
`endif
        step;

        // mixed traffic with intermittent stalls; counter wraps at 2^CW
        for (int i = 0; i < 48; i++) begin
            out_ready = (i % 3) != 0;
            if (i % 4 != 3)
                drive(2'(i), fl[i % 6], DW'(i * 7), DW'(i * 13), RW'(i % 4), RW'((i + 1) % 4), RW'(i % 4));
            else
                in_valid = 0;
            alu_result = DW'(i * 32'h1111);
            step;
        end
        in_valid = 0; out_ready = 1;
        repeat (4) step;

        // reset with both slots occupied
        out_ready = 0;
        drive(2'b00, 6'h0, 1, 1, 0, 0, 1); step;
        drive(2'b00, 6'h0, 2, 2, 0, 0, 2); step;
        Reset = 1; step;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cnt", issue_cnt, 0);
        chk("midrst_illegal", illegal_funct, 0);
        chk("midrst_src1", alu_src1, 0);
        Reset = 0; in_valid = 0; step;
        chk("midrst_rel_in_ready", in_ready, 1);
        chk("midrst_rel_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-stage issue block directly upstream of the ALU.
- Accepts decoded instructions (ALUOp, funct, operands, register tags) over a valid/ready handshake and derives the 3-bit ALU control code.
- Buffers instructions in a 2-entry skid buffer and presents registered alu_src1/alu_src2/alu_ctr to the ALU with a valid/ready handshake.
- Optionally forwards the last retired ALU result into operands.

Parameters:
- DW, 32, operand/result width
- RW, 5, register tag width
- CW, 16, issue counter width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept this cycle
- in_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- in_funct  in  6  R-type funct field
- in_src1  in  DW  operand 1 value
- in_src2  in  DW  operand 2 value
- in_rs  in  RW  operand 1 source tag
- in_rt  in  RW  operand 2 source tag
- in_dst  in  RW  destination tag
- out_valid  out  1  output entry valid
- out_ready  in  1  ALU/EX consumer accepts
- alu_src1  out  DW  ALU operand 1
- alu_src2  out  DW  ALU operand 2
- alu_ctr  out  3  ALU control code
- out_dst  out  RW  destination tag of output entry
- alu_result  in  DW  ALU result for the current output entry (forwarding only)
- illegal_funct  out  1  sticky: undefined funct was accepted
- issue_cnt  out  CW  count of output fires

Behaviour:
- Reset (synchronous, active-high): out_valid=0, skid empty, in_ready=0 during the Reset cycle and 1 afterwards. alu_src1/alu_src2/out_dst=0, alu_ctr=3'b010, illegal_funct=0, issue_cnt=0, forwarding record invalid. Reset mid-operation discards all buffered entries.
- Handshake:
  - accept = in_valid & in_ready
  - fire = out_valid & out_ready
  - Data is held stable while out_valid & !out_ready.
- Control decode, applied at accept:
  - ALUOp 00 -> 010 (add); 01 -> 110 (sub); 11 -> 001 (or).
  - ALUOp 10, by funct: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - Any other funct -> 010 and sets illegal_funct, which stays 1 until Reset.
- Skid buffer (output register O, skid register S). in_ready is registered: in_ready = !S.valid.
  - accept with O empty, or O firing and S empty: entry goes to O. Latency is 1 cycle from accept to out_valid.
  - accept while O valid and not firing: entry goes to S; in_ready drops the next cycle.
  - O firing with S valid: S moves to O and S empties. A simultaneous accept is impossible because in_ready=0.
  - Sustained throughput is 1 per cycle when out_ready is held high.
  - Order is strictly preserved.
- issue_cnt: +1 per fire, wraps from 2^CW-1 to 0.
- Tag 0 is treated as the zero register and is never a forwarding match.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN
- Defined:
  - On each fire, record last_dst=out_dst and last_res=alu_result, and mark the record valid.
  - At accept, in_src1 is replaced when in_rs matches (nonzero); in_src2 is replaced when in_rt matches.
  - Same-cycle fire (out_dst, alu_result) has priority over the stored record.
  - Forwarding is evaluated only at accept; entries already in S are not updated.
- Undefined: operands pass through unmodified, the alu_result port is unused, and no record state exists.

Test Plan:
- Reset held 2 cycles, then released -> out_valid=0, alu_ctr=010, issue_cnt=0; in_ready=1 one cycle after release.
- ALUOp=10, funct=101010, src1=5, src2=9, out_ready=1 -> next cycle out_valid=1, alu_ctr=111, alu_src1=5, alu_src2=9; issue_cnt=1 after fire.
- 3 back-to-back accepts with out_ready=0 -> O holds #1, S holds #2, in_ready=0, #3 not accepted. Raise out_ready -> #1, #2, #3 emerge in order, one per cycle.
- ALUOp=10, funct=000111 -> alu_ctr=010, illegal_funct=1 and stays 1 across later legal instructions until Reset.
- ALUOp=01, src1=0x10, src2=0x10 -> alu_ctr=110; ALU zero path sees a zero result.
- With ALU_ISSUE_FWD_EN: fire dst=3, alu_result=0xDEAD; the same cycle, accept rs=3, src1=0x1 -> alu_src1=0xDEAD. A later accept with rs=0 keeps its src1.
